pipe_hazard_ctrl: RTL

- Parametrised hazard-detection and forwarding controller for the ARM pipeline.
- Replaces the separate stateless hazard and forwarding units with a single controller that keeps its own shadow pipeline of in-flight destinations from EXE through WB.
- Adds three things the stateless units lack: configurable post-ID depth, multi-cycle memory-wait freeze, and saturating performance counters.
- Sits beside the ID stage; drives IF/ID freeze, EXE operand-mux selects and ID/EXE bubble insertion.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_perf_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Register fields are stored at REG_AW_MAX bits; narrower register addresses are zero-extended.
package pipe_ctrl_pkg;

    localparam int REG_AW_MAX = 8;
    localparam int FWD_RF     = 0;
    localparam int EXE        = 0;
    localparam int MEM        = 1;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_r_en;
        logic [REG_AW_MAX-1:0] dest;
        logic [REG_AW_MAX-1:0] src1;
        logic                  src1_used;
        logic [REG_AW_MAX-1:0] src2;
        logic                  src2_used;
    } trk_entry_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating, synchronously clearable event counter.
module pipe_perf_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= CNT_W'(sat_inc(32'(r_cnt), unsigned'(CNT_W)));
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and operand-forwarding controller with its own shadow tracker
// of in-flight instructions from EXE to WB, memory-wait freeze and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int STAGES = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              br_taken,
    input  logic              mem_busy,
    input  logic              clr_cnt,
    output logic              freeze,
    output logic              ex_bubble,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]  hazard_cnt,
    output logic [CNT_W-1:0]  memwait_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // WB writes the register file in the first half-cycle, so it is excluded from stalls.
    localparam logic [STAGES-1:0] STALL_MASK = {1'b0, {(STAGES-1){1'b1}}};

    trk_entry_t              r_trk [STAGES];
    trk_entry_t              w_id_entry;
    logic [REG_AW_MAX-1:0]   w_src1;
    logic [REG_AW_MAX-1:0]   w_src2;
    logic [STAGES-1:0]       w_m1;
    logic [STAGES-1:0]       w_m2;
    logic [STAGES-1:0]       w_e1;
    logic [STAGES-1:0]       w_e2;
    logic                    w_load_use;
    logic                    w_raw_any;
    logic                    w_hazard;
    logic [SEL_W-1:0]        w_sel1;
    logic [SEL_W-1:0]        w_sel2;

    assign w_src1 = REG_AW_MAX'(id_src1);
    assign w_src2 = REG_AW_MAX'(id_src2);

    // w_m*: ID operand vs tracked stage; w_e*: EXE operand vs tracked stage.
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        w_e1 = '0;
        w_e2 = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_m1[s] = r_trk[s].valid && r_trk[s].wb_en && (r_trk[s].dest == w_src1) && id_src1_used;
            w_m2[s] = r_trk[s].valid && r_trk[s].wb_en && (r_trk[s].dest == w_src2) && id_src2_used;
            w_e1[s] = r_trk[EXE].valid && r_trk[EXE].src1_used && r_trk[s].valid && r_trk[s].wb_en
                      && (r_trk[s].dest == r_trk[EXE].src1);
            w_e2[s] = r_trk[EXE].valid && r_trk[EXE].src2_used && r_trk[s].valid && r_trk[s].wb_en
                      && (r_trk[s].dest == r_trk[EXE].src2);
        end
    end

    assign w_load_use = r_trk[EXE].mem_r_en && (w_m1[EXE] || w_m2[EXE]);
    assign w_raw_any  = |((w_m1 | w_m2) & STALL_MASK);
    assign w_hazard   = id_valid && (fwd_en ? w_load_use : w_raw_any);

    assign freeze    = w_hazard || mem_busy;
    assign ex_bubble = (w_hazard || br_taken) && !mem_busy;

    // Scan from WB towards MEM so the nearest producer is the last one written.
    always_comb begin
        w_sel1 = SEL_W'(FWD_RF);
        w_sel2 = SEL_W'(FWD_RF);
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (!(k == MEM && r_trk[MEM].mem_r_en)) begin
                if (w_e1[k]) w_sel1 = SEL_W'(k);
                if (w_e2[k]) w_sel2 = SEL_W'(k);
            end
        end
    end

    assign fwd_sel1 = fwd_en ? w_sel1 : SEL_W'(FWD_RF);
    assign fwd_sel2 = fwd_en ? w_sel2 : SEL_W'(FWD_RF);

    always_comb begin
        w_id_entry           = '0;
        w_id_entry.valid     = id_valid && !ex_bubble;
        w_id_entry.wb_en     = id_wb_en;
        w_id_entry.mem_r_en  = id_mem_r_en;
        w_id_entry.dest      = REG_AW_MAX'(id_dest);
        w_id_entry.src1      = w_src1;
        w_id_entry.src1_used = id_src1_used;
        w_id_entry.src2      = w_src2;
        w_id_entry.src2_used = id_src2_used;
    end

    // Tracker advance: only the valid bits are reset; payload is don't-care when invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) r_trk[s].valid <= 1'b0;
        end else if (!mem_busy) begin
            for (int s = 1; s < STAGES; s++) r_trk[s] <= r_trk[s-1];
            r_trk[EXE] <= w_id_entry;
        end
    end

    pipe_perf_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_hazard && !mem_busy && !br_taken),
        .cnt (hazard_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (mem_busy),
        .cnt (memwait_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (br_taken && !mem_busy),
        .cnt (flush_cnt)
    );

endmodule
